// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter mode sequencer: state encoding,
// shift-register mode codes, counter mode codes and the per-state output decode.
package counter_ctrl_pkg;

    // Sequencer states; the encoding is visible on the phase output.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLR    = 4'd1,
        ST_UP_BIN = 4'd2,
        ST_DN_BIN = 4'd3,
        ST_UP_BCD = 4'd4,
        ST_DN_BCD = 4'd5,
        ST_LOAD   = 4'd6,
        ST_SHR    = 4'd7,
        ST_SHL    = 4'd8
    } state_t;

    // Shift register SEL3 codes.
    localparam logic [1:0] SH_PAR   = 2'b00;
    localparam logic [1:0] SH_RIGHT = 2'b01;
    localparam logic [1:0] SH_LEFT  = 2'b10;

    // Counter modes as {sel1, sel2}: sel1 = 1 counts up, sel2 = 1 selects BCD.
    localparam logic [1:0] MODE_UP_BIN = 2'b10;
    localparam logic [1:0] MODE_DN_BIN = 2'b00;
    localparam logic [1:0] MODE_UP_BCD = 2'b11;
    localparam logic [1:0] MODE_DN_BCD = 2'b01;

    // Control word driven towards the counter and shift register.
    typedef struct packed {
        logic       cnt_rstn;
        logic       en;
        logic [1:0] mode;
        logic [1:0] sel3;
    } ctrl_t;

    // Moore output decode; any unexpected encoding falls back to the idle word.
    function automatic ctrl_t decode_state(input state_t st);
        ctrl_t c;
        c.cnt_rstn = 1'b0;
        c.en       = 1'b1;
        c.mode     = MODE_UP_BIN;
        c.sel3     = SH_PAR;
        case (st)
            ST_IDLE, ST_CLR: begin
                c.cnt_rstn = 1'b0; c.en = 1'b1; c.mode = MODE_UP_BIN; c.sel3 = SH_PAR;
            end
            ST_UP_BIN: begin
                c.cnt_rstn = 1'b1; c.en = 1'b1; c.mode = MODE_UP_BIN; c.sel3 = SH_PAR;
            end
            ST_DN_BIN: begin
                c.cnt_rstn = 1'b1; c.en = 1'b1; c.mode = MODE_DN_BIN; c.sel3 = SH_PAR;
            end
            ST_UP_BCD: begin
                c.cnt_rstn = 1'b1; c.en = 1'b1; c.mode = MODE_UP_BCD; c.sel3 = SH_PAR;
            end
            ST_DN_BCD: begin
                c.cnt_rstn = 1'b1; c.en = 1'b1; c.mode = MODE_DN_BCD; c.sel3 = SH_PAR;
            end
            ST_LOAD: begin
                c.cnt_rstn = 1'b1; c.en = 1'b0; c.mode = MODE_DN_BCD; c.sel3 = SH_PAR;
            end
            ST_SHR: begin
                c.cnt_rstn = 1'b1; c.en = 1'b0; c.mode = MODE_DN_BCD; c.sel3 = SH_RIGHT;
            end
            ST_SHL: begin
                c.cnt_rstn = 1'b1; c.en = 1'b0; c.mode = MODE_DN_BCD; c.sel3 = SH_LEFT;
            end
            default: begin
                c.cnt_rstn = 1'b0; c.en = 1'b1; c.mode = MODE_UP_BIN; c.sel3 = SH_PAR;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/counter_mode_sequencer_dwell_timer.sv
// Loadable down-counter measuring how long the sequencer stays in a state.
// Loaded with (dwell - 1) on state entry; last is high in the final cycle.
module dwell_timer
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             last
);

    logic [WIDTH-1:0] count_r;

    // Remaining-cycle counter: hold freezes it, load restarts it, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (hold) begin
            count_r <= count_r;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign last = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/counter_mode_sequencer.sv
// Autonomous sequencer that clears the BIN/BCD counter, walks it through its four
// counting modes, then drives the shift register through load, right and left shift.
module counter_mode_sequencer
    import counter_ctrl_pkg::*;
#(
    parameter int DWELL       = 40,
    parameter int SHIFT_DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    input  logic       loop,
    input  logic [3:0] preset_in,
    output logic       cnt_rstn,
    output logic       en,
    output logic       sel1,
    output logic       sel2,
    output logic [1:0] sel3,
    output logic [3:0] preset,
    output logic       busy,
    output logic       done,
    output logic [3:0] phase
);

    localparam int MAX_DWELL = (DWELL > SHIFT_DWELL) ? DWELL : SHIFT_DWELL;
    localparam int TW        = $clog2(MAX_DWELL + 1);
    localparam logic [TW-1:0] CNT_DWELL = TW'(DWELL - 1);
    localparam logic [TW-1:0] CNT_SHIFT = TW'(SHIFT_DWELL - 1);
    localparam logic [TW-1:0] CNT_ZERO  = {TW{1'b0}};

    state_t          state_r;
    state_t          next_state_s;
    logic            last_s;
    logic            load_s;
    logic            accept_s;
    logic            exit_s;
    logic [TW-1:0]   load_val_s;
    ctrl_t           ctrl_s;

    dwell_timer #(
        .WIDTH (TW)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .load     (load_s),
        .load_val (load_val_s),
        .last     (last_s)
    );

    // Next-state logic: hold freezes everything, otherwise advance on the last dwell cycle.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        exit_s       = 1'b0;
        if (hold) begin
            next_state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        next_state_s = ST_CLR;
                        accept_s     = 1'b1;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_CLR:    next_state_s = last_s ? ST_UP_BIN : ST_CLR;
                ST_UP_BIN: next_state_s = last_s ? ST_DN_BIN : ST_UP_BIN;
                ST_DN_BIN: next_state_s = last_s ? ST_UP_BCD : ST_DN_BIN;
                ST_UP_BCD: next_state_s = last_s ? ST_DN_BCD : ST_UP_BCD;
                ST_DN_BCD: next_state_s = last_s ? ST_LOAD   : ST_DN_BCD;
                ST_LOAD:   next_state_s = last_s ? ST_SHR    : ST_LOAD;
                ST_SHR:    next_state_s = last_s ? ST_SHL    : ST_SHR;
                ST_SHL: begin
                    if (last_s) begin
                        exit_s       = 1'b1;
                        next_state_s = loop ? ST_CLR : ST_IDLE;
                    end else begin
                        next_state_s = ST_SHL;
                    end
                end
                default:   next_state_s = ST_IDLE;
            endcase
        end
    end

    // Dwell reload value for the state being entered (CLR, LOAD and IDLE last one cycle).
    always_comb begin
        load_val_s = CNT_ZERO;
        case (next_state_s)
            ST_UP_BIN, ST_DN_BIN, ST_UP_BCD, ST_DN_BCD: load_val_s = CNT_DWELL;
            ST_SHR, ST_SHL:                             load_val_s = CNT_SHIFT;
            default:                                    load_val_s = CNT_ZERO;
        endcase
    end

    assign load_s = (next_state_s != state_r);
    assign ctrl_s = decode_state(next_state_s);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered Moore outputs decoded from the next state so they align with state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_rstn <= 1'b0;
            en       <= 1'b1;
            sel1     <= 1'b1;
            sel2     <= 1'b0;
            sel3     <= SH_PAR;
            preset   <= 4'hF;
            busy     <= 1'b0;
            done     <= 1'b0;
            phase    <= 4'h0;
        end else begin
            cnt_rstn     <= ctrl_s.cnt_rstn;
            en           <= ctrl_s.en;
            {sel1, sel2} <= ctrl_s.mode;
            sel3         <= ctrl_s.sel3;
            busy         <= (next_state_s != ST_IDLE);
            done         <= exit_s;
            phase        <= next_state_s;
            if (accept_s) begin
                preset <= preset_in;
            end else begin
                preset <= preset;
            end
        end
    end

endmodule
